// File: rtl/satd_block_loader.sv
// Row loader for the SATD block interface. Rows are collected into a fill buffer, and each
// complete block is copied as a whole into a presented buffer that stays stable until released.
module satd_block_loader #(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned NUM_INPUTS = 8,
    parameter  int unsigned ITERATIONS = 7,
    localparam int unsigned ROW_W      = WIDTH * NUM_INPUTS,
    localparam int unsigned ROWS       = ITERATIONS + 1,
    localparam int unsigned BLK_W      = ROW_W * ROWS,
    localparam int unsigned IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROW_W-1:0]   in_org,
    input  logic [ROW_W-1:0]   in_cur,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLK_W-1:0]   ORG,
    output logic [BLK_W-1:0]   CUR,
    output logic [IDX_W-1:0]   row_idx,
    output logic [15:0]        blk_count
);

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic                        in_ready_q, in_ready_d;
    logic [IDX_W-1:0]            row_idx_q, row_idx_d;
    logic [ROWS-1:0][ROW_W-1:0]  fill_org_q, fill_org_d;
    logic [ROWS-1:0][ROW_W-1:0]  fill_cur_q, fill_cur_d;
    logic [BLK_W-1:0]            org_q, org_d;
    logic [BLK_W-1:0]            cur_q, cur_d;
    logic                        blk_valid_q, blk_valid_d;
    logic [15:0]                 blk_count_q, blk_count_d;

    logic accept;
    logic last_row;
    logic slot_free;
    logic swap;

    assign accept    = in_valid && in_ready_q;
    assign last_row  = (row_idx_q == IDX_W'(ITERATIONS));
    // A release seen on the same edge frees the presented slot for an immediate swap.
    assign slot_free = !blk_valid_q || blk_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
            row_idx_q   <= '0;
            fill_org_q  <= '0;
            fill_cur_q  <= '0;
            org_q       <= '0;
            cur_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            row_idx_q   <= row_idx_d;
            fill_org_q  <= fill_org_d;
            fill_cur_q  <= fill_cur_d;
            org_q       <= org_d;
            cur_q       <= cur_d;
            blk_valid_q <= blk_valid_d;
            blk_count_q <= blk_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        fill_org_d  = fill_org_q;
        fill_cur_d  = fill_cur_q;
        org_d       = org_q;
        cur_d       = cur_q;
        blk_valid_d = blk_valid_q;
        blk_count_d = blk_count_q;
        swap        = 1'b0;

        if (accept) begin
            fill_org_d[row_idx_q] = in_org;
            fill_cur_d[row_idx_q] = in_cur;
            row_idx_d = last_row ? '0 : row_idx_q + IDX_W'(1);
        end

        case (state_q)
            FILL: begin
                if (accept && last_row) begin
                    if (slot_free) swap = 1'b1;
                    else           state_d = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (slot_free) begin
                    swap    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // Swap copies the updated fill buffer so the completing row is not lost.
        if (swap) begin
            org_d       = fill_org_d;
            cur_d       = fill_cur_d;
            blk_valid_d = 1'b1;
            blk_count_d = blk_count_q + 16'd1;
        end else if (blk_valid_q && blk_ready) begin
            blk_valid_d = 1'b0;
        end

        in_ready_d = (state_d == FILL);
    end

    assign in_ready  = in_ready_q;
    assign row_idx   = row_idx_q;
    assign ORG       = org_q;
    assign CUR       = cur_q;
    assign blk_valid = blk_valid_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_satd_block_loader.sv
// Bench for satd_block_loader: directed handshake scenarios plus a randomized run checked
// against a block-level scoreboard.
module tb_satd_block_loader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NUM_INPUTS = 8;
    localparam int unsigned ITERATIONS = 7;
    localparam int unsigned ROW_W = WIDTH * NUM_INPUTS;
    localparam int unsigned ROWS = ITERATIONS + 1;
    localparam int unsigned BLK_W = ROW_W * ROWS;
    localparam int unsigned IDX_W = 3;
    localparam int NBLK = 300;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_org;
    logic [ROW_W-1:0] in_cur;
    logic             blk_valid;
    logic             blk_ready;
    logic [BLK_W-1:0] ORG;
    logic [BLK_W-1:0] CUR;
    logic [IDX_W-1:0] row_idx;
    logic [15:0]      blk_count;

    int checks = 0;
    int failures = 0;

    logic [BLK_W-1:0] blk1_org, blk1_cur, blk2_org, blk2_cur, blk3_org, blk3_cur;

    satd_block_loader #(
        .WIDTH(WIDTH), .NUM_INPUTS(NUM_INPUTS), .ITERATIONS(ITERATIONS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_org(in_org), .in_cur(in_cur), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .ORG(ORG), .CUR(CUR), .row_idx(row_idx), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        return {$urandom(), $urandom()};
    endfunction

    // Drives one row and holds it until accepted (bounded).
    task automatic send_row(input logic [ROW_W-1:0] o, input logic [ROW_W-1:0] c);
        int n = 0;
        in_org = o;
        in_cur = c;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_row_timeout in_ready=%0b required=1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [BLK_W-1:0] o, input logic [BLK_W-1:0] c);
        for (int r = 0; r < int'(ROWS); r++)
            send_row(o[r*ROW_W +: ROW_W], c[r*ROW_W +: ROW_W]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int r = 0; r < 3; r++) send_row(rand_row(), rand_row());
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (blk_valid !== 1'b0) begin failures++; $display("FAIL reset_blk_valid got=%0b exp=0", blk_valid); end
        checks++;
        if (row_idx !== 3'd0) begin failures++; $display("FAIL reset_row_idx got=%0d exp=0", row_idx); end
        checks++;
        if (ORG !== '0 || CUR !== '0) begin failures++; $display("FAIL reset_org_cur got_org=%h exp=0", ORG); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++;
        if (blk_count !== 16'd0) begin failures++; $display("FAIL reset_blk_count got=%0d exp=0", blk_count); end
    endtask

    task automatic test_single_block();
        for (int r = 0; r < int'(ROWS); r++)
            for (int p = 0; p < int'(NUM_INPUTS); p++) begin
                blk1_org[(r*ROW_W) + p*WIDTH +: WIDTH] = 8'(r*8 + p);
                blk1_cur[(r*ROW_W) + p*WIDTH +: WIDTH] = 8'(8'hFF - (r*8 + p));
            end
        blk_ready = 1'b0;
        for (int r = 0; r < int'(ROWS) - 1; r++) begin
            send_row(blk1_org[r*ROW_W +: ROW_W], blk1_cur[r*ROW_W +: ROW_W]);
            checks++;
            if (blk_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid row=%0d got=%0b exp=0", r, blk_valid); end
        end
        send_row(blk1_org[(ROWS-1)*ROW_W +: ROW_W], blk1_cur[(ROWS-1)*ROW_W +: ROW_W]);
        checks++;
        if (blk_valid !== 1'b1) begin failures++; $display("FAIL single_blk_valid got=%0b exp=1", blk_valid); end
        checks++;
        if (ORG[7:0] !== 8'h00 || ORG[511:504] !== 8'h3F || CUR[7:0] !== 8'hFF) begin
            failures++;
            $display("FAIL single_corners got=%h/%h/%h exp=00/3f/ff", ORG[7:0], ORG[511:504], CUR[7:0]);
        end
        checks++;
        if (ORG !== blk1_org || CUR !== blk1_cur) begin failures++; $display("FAIL single_data got=%h exp=%h", ORG, blk1_org); end
        checks++;
        if (blk_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", blk_count); end
    endtask

    task automatic test_stall();
        for (int r = 0; r < int'(ROWS); r++) begin
            blk2_org[r*ROW_W +: ROW_W] = rand_row();
            blk2_cur[r*ROW_W +: ROW_W] = rand_row();
        end
        blk_ready = 1'b0;
        send_block(blk2_org, blk2_cur);
        cycle();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
        checks++;
        if (ORG !== blk1_org || CUR !== blk1_cur || blk_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold got=%h valid=%0b exp=%h valid=1", ORG, blk_valid, blk1_org);
        end
        checks++;
        if (blk_count !== 16'd1) begin failures++; $display("FAIL stall_count got=%0d exp=1", blk_count); end
        blk_ready = 1'b1;
        cycle();
        blk_ready = 1'b0;
        checks++;
        if (ORG !== blk2_org || CUR !== blk2_cur || blk_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_swap got=%h valid=%0b exp=%h valid=1", ORG, blk_valid, blk2_org);
        end
        checks++;
        if (blk_count !== 16'd2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_after count=%0d in_ready=%0b exp count=2 in_ready=1", blk_count, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < int'(ROWS); r++) begin
            blk3_org[r*ROW_W +: ROW_W] = rand_row();
            blk3_cur[r*ROW_W +: ROW_W] = rand_row();
        end
        blk_ready = 1'b0;
        for (int r = 0; r < int'(ROWS) - 1; r++)
            send_row(blk3_org[r*ROW_W +: ROW_W], blk3_cur[r*ROW_W +: ROW_W]);
        checks++;
        if (ORG !== blk2_org) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", ORG, blk2_org); end
        blk_ready = 1'b1;
        send_row(blk3_org[(ROWS-1)*ROW_W +: ROW_W], blk3_cur[(ROWS-1)*ROW_W +: ROW_W]);
        blk_ready = 1'b0;
        checks++;
        if (blk_valid !== 1'b1 || ORG !== blk3_org || CUR !== blk3_cur) begin
            failures++;
            $display("FAIL b2b_swap valid=%0b got=%h exp=%h", blk_valid, ORG, blk3_org);
        end
        checks++;
        if (blk_count !== 16'd3 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_state count=%0d in_ready=%0b exp count=3 in_ready=1", blk_count, in_ready);
        end
    endtask

    task automatic test_release_idle();
        blk_ready = 1'b1;
        cycle();
        blk_ready = 1'b0;
        checks++;
        if (blk_valid !== 1'b0 || ORG !== blk3_org || CUR !== blk3_cur) begin
            failures++;
            $display("FAIL release valid=%0b got=%h exp valid=0 data=%h", blk_valid, ORG, blk3_org);
        end
        for (int i = 0; i < 2; i++) begin
            blk_ready = 1'b1;
            cycle();
            blk_ready = 1'b0;
            cycle();
        end
        checks++;
        if (blk_valid !== 1'b0 || ORG !== blk3_org || blk_count !== 16'd3) begin
            failures++;
            $display("FAIL release_idle valid=%0b count=%0d exp valid=0 count=3", blk_valid, blk_count);
        end
    endtask

    task automatic test_gaps();
        logic [BLK_W-1:0] exp_org[$];
        logic [BLK_W-1:0] exp_cur[$];
        logic [BLK_W-1:0] bld_org, bld_cur;
        int row_cnt = 0;
        int produced = 0;
        int consumed = 0;
        int cyc = 0;
        int errs = 0;
        bld_org = '0;
        bld_cur = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        while (consumed < NBLK && cyc < 40000) begin
            in_valid  = (produced < NBLK * int'(ROWS)) && ($urandom_range(3) != 0);
            in_org    = rand_row();
            in_cur    = rand_row();
            blk_ready = (produced >= NBLK * int'(ROWS)) || ($urandom_range(2) != 0);
            #1;
            if (in_valid && in_ready) begin
                bld_org[row_cnt*ROW_W +: ROW_W] = in_org;
                bld_cur[row_cnt*ROW_W +: ROW_W] = in_cur;
                row_cnt++;
                produced++;
                if (row_cnt == int'(ROWS)) begin
                    exp_org.push_back(bld_org);
                    exp_cur.push_back(bld_cur);
                    row_cnt = 0;
                end
            end
            if (blk_valid && blk_ready) begin
                checks++;
                if (exp_org.size() == 0) begin
                    failures++;
                    $display("FAIL gaps_unexpected_block idx=%0d got=%h exp=none", consumed, ORG);
                end else begin
                    if (ORG !== exp_org[0] || CUR !== exp_cur[0]) begin
                        failures++;
                        errs++;
                        if (errs < 5) $display("FAIL gaps_block idx=%0d got=%h exp=%h", consumed, ORG, exp_org[0]);
                    end
                    void'(exp_org.pop_front());
                    void'(exp_cur.pop_front());
                end
                consumed++;
            end
            cycle();
            cyc++;
        end
        in_valid = 1'b0;
        blk_ready = 1'b0;
        checks++;
        if (consumed != NBLK || exp_org.size() != 0) begin
            failures++;
            $display("FAIL gaps_consumed got=%0d pending=%0d exp=%0d pending=0", consumed, exp_org.size(), NBLK);
        end
        checks++;
        if (blk_count !== 16'(NBLK)) begin failures++; $display("FAIL gaps_count got=%0d exp=%0d", blk_count, NBLK); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_org = '0;
        in_cur = '0;
        blk_ready = 1'b0;
        test_reset();
        test_single_block();
        test_stall();
        test_back_to_back();
        test_release_idle();
        test_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
